// File: rtl/commit_trace_writer.sv
// Commit trace writer: captures dual-channel writeback commits into a record FIFO and drains them.
// Optional build macro TRACE_EXC_FILTER_EN drops commits whose PC lies in 0xbfc00380..0xbfc00387.
module commit_trace_writer #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] END_PC     = 32'hbfc00100
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        trace_open,
    input  logic        wb0_en,
    input  logic [4:0]  wb0_rd,
    input  logic [31:0] wb0_wdata,
    input  logic [31:0] wb0_pc,
    input  logic        wb1_en,
    input  logic [4:0]  wb1_rd,
    input  logic [31:0] wb1_wdata,
    input  logic [31:0] wb1_pc,
    output logic        in_ready,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [31:0] rec_pc,
    output logic [4:0]  rec_wnum,
    output logic [31:0] rec_wdata,
    output logic        rec_flag,
    output logic        overflow,
    output logic [31:0] rec_count,
    output logic        done
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] NearFull = (AW+1)'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic        flag;
    } rec_t;

    state_e      state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        overflow_q, overflow_d;
    logic [31:0] count_q, count_d;
    rec_t        mem_q [FIFO_DEPTH];

    logic          filt0, filt1, take0, take1, end0, end1;
    logic          capture, fits, do_push, pop, empty, full;
    logic [1:0]    push_cnt;
    logic [AW:0]   used;
    logic [AW-1:0] widx0, widx1;
    rec_t          rec0, rec1, head;

`ifdef TRACE_EXC_FILTER_EN
    assign filt0 = (wb0_pc[31:3] == {28'hbfc0038, 1'b0});
    assign filt1 = (wb1_pc[31:3] == {28'hbfc0038, 1'b0});
`else
    assign filt0 = 1'b0;
    assign filt1 = 1'b0;
`endif

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        used     = wr_ptr_q - rd_ptr_q;
        in_ready = !full && (used != NearFull);

        capture  = (state_q == StRun) && trace_open;
        take0    = wb0_en && !filt0;
        end0     = take0 && (wb0_pc == END_PC);
        // A terminating PC on channel 0 ends the trace, so channel 1 of that cycle is dropped.
        take1    = wb1_en && !filt1 && !end0;
        end1     = take1 && (wb1_pc == END_PC);
        push_cnt = {1'b0, take0} + {1'b0, take1};

        // All-or-nothing: a cycle's records are pushed only if every one of them fits.
        fits     = (push_cnt == 2'd2) ? in_ready : ((push_cnt == 2'd1) ? !full : 1'b1);
        do_push  = capture && fits && (push_cnt != 2'd0);
        pop      = !empty && rec_ready;

        widx0    = wr_ptr_q[AW-1:0];
        widx1    = widx0 + {{(AW-1){1'b0}}, take0};
        rec0     = '{pc: wb0_pc, wnum: wb0_rd, wdata: wb0_wdata, flag: trace_open};
        rec1     = '{pc: wb1_pc, wnum: wb1_rd, wdata: wb1_wdata, flag: trace_open};

        wr_ptr_d   = do_push ? (wr_ptr_q + {{(AW-1){1'b0}}, push_cnt}) : wr_ptr_q;
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
        overflow_d = overflow_q || (capture && !fits);
        count_d    = count_q + {31'b0, pop};

        state_d = state_q;
        case (state_q)
            StIdle: if (trace_open) state_d = StRun;
            StRun: begin
                if (do_push && (end0 || end1)) begin
                    state_d = StDone;
                end else if (!trace_open) begin
                    state_d = StIdle;
                end
            end
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: contents are only visible while the pointers say non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            if (take0) mem_q[widx0] <= rec0;
            if (take1) mem_q[widx1] <= rec1;
        end
    end

    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign rec_valid = !empty;
    assign rec_pc    = rec_valid ? head.pc    : '0;
    assign rec_wnum  = rec_valid ? head.wnum  : '0;
    assign rec_wdata = rec_valid ? head.wdata : '0;
    assign rec_flag  = rec_valid ? head.flag  : 1'b0;
    assign overflow  = overflow_q;
    assign rec_count = count_q;
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_commit_trace_writer.sv
// Scoreboard bench for commit_trace_writer: stimulus task plans expected records, a negedge
// monitor pops and compares them whenever the DUT hands a record over.
module tb_commit_trace_writer;

    localparam int          DEPTH  = 8;
    localparam logic [31:0] END_PC = 32'hbfc00100;
`ifdef TRACE_EXC_FILTER_EN
    localparam int EXP_FILT_CNT = 0;
`else
    localparam int EXP_FILT_CNT = 1;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        trace_open = 1'b0;
    logic        wb0_en = 1'b0, wb1_en = 1'b0;
    logic [4:0]  wb0_rd = '0, wb1_rd = '0;
    logic [31:0] wb0_wdata = '0, wb1_wdata = '0, wb0_pc = '0, wb1_pc = '0;
    logic        rec_ready = 1'b0;
    logic        in_ready, rec_valid, rec_flag, overflow, done;
    logic [31:0] rec_pc, rec_wdata, rec_count;
    logic [4:0]  rec_wnum;

    commit_trace_writer #(.FIFO_DEPTH(DEPTH), .END_PC(END_PC)) dut (
        .clk(clk), .resetn(resetn), .trace_open(trace_open),
        .wb0_en(wb0_en), .wb0_rd(wb0_rd), .wb0_wdata(wb0_wdata), .wb0_pc(wb0_pc),
        .wb1_en(wb1_en), .wb1_rd(wb1_rd), .wb1_wdata(wb1_wdata), .wb1_pc(wb1_pc),
        .in_ready(in_ready), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_pc(rec_pc), .rec_wnum(rec_wnum), .rec_wdata(rec_wdata), .rec_flag(rec_flag),
        .overflow(overflow), .rec_count(rec_count), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic        flag;
    } rec_t;

    // Model: 0 = idle, 1 = running, 2 = finished. m_* is the state after the last edge,
    // p_* / pend_q is what the next edge will produce.
    rec_t        exp_q[$];
    rec_t        pend_q[$];
    rec_t        mon_e;
    int          m_state = 0, p_state = 0;
    bit          m_ovf = 1'b0, p_ovf = 1'b0;
    int unsigned m_pops = 0;
    int          passes = 0, total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        check("rec_valid", rec_valid, exp_q.size() != 0);
        check("in_ready", in_ready, (DEPTH - exp_q.size()) >= 2);
        check("overflow", overflow, m_ovf);
        check("done", done, m_state == 2);
        check("rec_count", rec_count, m_pops);
        if (rec_valid && rec_ready && exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("rec_pc", rec_pc, mon_e.pc);
            check("rec_wnum", rec_wnum, mon_e.wnum);
            check("rec_wdata", rec_wdata, mon_e.wdata);
            check("rec_flag", rec_flag, mon_e.flag);
            m_pops++;
        end
    end

    function automatic bit in_exc_window(input logic [31:0] pc);
`ifdef TRACE_EXC_FILTER_EN
        return pc >= 32'hbfc00380 && pc <= 32'hbfc00387;
`else
        return 1'b0;
`endif
    endfunction

    task automatic commit_edge();
        foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
        pend_q.delete();
        m_state = p_state;
        m_ovf   = p_ovf;
    endtask

    task automatic plan();
        rec_t c[$];
        p_state = m_state;
        p_ovf   = m_ovf;
        if (m_state == 1 && trace_open) begin
            if (wb0_en && !in_exc_window(wb0_pc))
                c.push_back('{wb0_pc, wb0_rd, wb0_wdata, trace_open});
            if (wb1_en && !(wb0_en && wb0_pc == END_PC) && !in_exc_window(wb1_pc))
                c.push_back('{wb1_pc, wb1_rd, wb1_wdata, trace_open});
            if (c.size() > DEPTH - exp_q.size()) begin
                p_ovf = 1'b1;
            end else begin
                pend_q = c;
                foreach (c[i]) if (c[i].pc == END_PC) p_state = 2;
            end
        end else if (m_state == 1) begin
            p_state = 0;
        end else if (m_state == 0 && trace_open) begin
            p_state = 1;
        end
    endtask

    task automatic step(input bit open, input bit rdy,
                        input bit e0, input logic [31:0] pc0, input logic [4:0] rd0,
                        input logic [31:0] d0,
                        input bit e1, input logic [31:0] pc1, input logic [4:0] rd1,
                        input logic [31:0] d1);
        @(posedge clk);
        #1;
        commit_edge();
        trace_open = open; rec_ready = rdy;
        wb0_en = e0; wb0_pc = pc0; wb0_rd = rd0; wb0_wdata = d0;
        wb1_en = e1; wb1_pc = pc1; wb1_rd = rd1; wb1_wdata = d1;
        plan();
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        if ($urandom_range(0, 15) == 0) p = 32'hbfc00380 + $urandom_range(0, 11);
        else p = $urandom;
        if (p == END_PC) p = p + 32'd4;
        return p;
    endfunction

    task automatic rstep(input bit open, input bit rdy, input bit e0, input bit e1);
        step(open, rdy, e0, rand_pc(), 5'($urandom), $urandom,
             e1, rand_pc(), 5'($urandom), $urandom);
    endtask

    task automatic idle(input int n, input bit open, input bit rdy);
        for (int i = 0; i < n; i++) step(open, rdy, 0, '0, '0, '0, 0, '0, '0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        commit_edge();
        resetn = 1'b0; trace_open = 1'b0; rec_ready = 1'b0; wb0_en = 1'b0; wb1_en = 1'b0;
        exp_q.delete(); pend_q.delete();
        m_state = 0; p_state = 0; m_ovf = 1'b0; p_ovf = 1'b0; m_pops = 0;
        #1;
        check("rst_rec_valid", rec_valid, 0);
        check("rst_rec_pc", rec_pc, 0);
        check("rst_rec_wnum", rec_wnum, 0);
        check("rst_rec_wdata", rec_wdata, 0);
        check("rst_rec_flag", rec_flag, 0);
        check("rst_overflow", overflow, 0);
        check("rst_rec_count", rec_count, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        do_reset();

        // Dual commit in one cycle, drained in order.
        idle(1, 1, 1);
        step(1, 1, 1, 32'hbfc009c4, 5'd5, 32'h11, 1, 32'hbfc009c8, 5'd6, 32'h22);
        idle(4, 1, 1);
        check("dual_rec_count", rec_count, 2);

        // Five dual commits into a stalled 8-deep FIFO: the fifth cycle is dropped.
        do_reset();
        idle(1, 1, 0);
        for (int i = 0; i < 5; i++) rstep(1, 0, 1, 1);
        idle(1, 1, 0);
        check("ovf_sticky", overflow, 1);
        check("ovf_in_ready_full", in_ready, 0);
        idle(1, 1, 1);
        idle(2, 1, 0);
        check("ovf_in_ready_7", in_ready, 0);
        idle(10, 1, 1);

        // Capture gated by trace_open; reopening resumes with flag set.
        do_reset();
        for (int i = 0; i < 3; i++) rstep(0, 1, 1, 1);
        rstep(1, 1, 1, 1);
        rstep(1, 1, 1, 1);
        rstep(0, 1, 1, 1);
        idle(2, 0, 1);
        rstep(1, 1, 1, 1);
        rstep(1, 1, 1, 0);
        idle(4, 1, 1);
        check("open_gate_count", rec_count, 3);

        // Exception-vector commit: filtered only when the macro is defined.
        do_reset();
        idle(1, 1, 1);
        step(1, 1, 1, 32'hbfc00380, 5'd1, 32'hdead, 0, '0, '0, '0);
        idle(4, 1, 1);
        check("exc_window_count", rec_count, EXP_FILT_CNT);

        // Randomised traffic with occasional closes and back-pressure.
        do_reset();
        for (int i = 0; i < 1500; i++)
            rstep($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
        idle(12, 1, 1);

        // Mid-stream reset at occupancy 3 after an overflow.
        do_reset();
        idle(1, 1, 0);
        for (int i = 0; i < 5; i++) rstep(1, 0, 1, 1);
        idle(1, 1, 0);
        idle(5, 1, 1);
        idle(1, 1, 0);
        do_reset();
        idle(3, 1, 1);
        check("post_rst_count", rec_count, 0);

        // Terminating PC on channel 0 with channel 1 valid; later commits ignored.
        do_reset();
        idle(1, 1, 0);
        rstep(1, 0, 1, 1);
        step(1, 0, 1, END_PC, 5'd9, 32'h99, 1, 32'hbfc00104, 5'd10, 32'haa);
        for (int i = 0; i < 4; i++) rstep(1, 0, 1, 1);
        idle(8, 1, 1);
        check("end_done", done, 1);
        check("end_rec_count", rec_count, 3);
        check("end_drained", rec_valid, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
